// File: rtl/sda_link_pkg.sv
// sda_link_pkg: definitions shared by both ends of the scl/sda link
// (the parallel-to-serial transmitter and the sda_to_par receiver).
//   state_t    : receiver/transmitter frame state
//   DATA_W_DEF : default number of data bits per frame
//   LINE_IDLE  : level of an idle (pulled-up) bus line
package sda_link_pkg;

  localparam int DATA_W_DEF = 4;

  localparam logic LINE_IDLE = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BITS = 2'd1,
    STOP = 2'd2
  } state_t;

endpackage

// File: rtl/sda_link_sampler.sv
// sda_link_sampler: registers the scl/sda lines into the sclk domain and
// decodes link events from the current and previous samples.
//   sclk   in  system clock
//   rst    in  asynchronous active-low reset
//   scl    in  link clock (sampled only)
//   sda    in  link data
//   c_sda  out most recent sda sample
//   rise   out scl went low -> high
//   start  out sda fell while scl stayed high
//   stop   out sda rose while scl stayed high
module sda_link_sampler
  import sda_link_pkg::*;
(
  input  logic sclk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic c_sda,
  output logic rise,
  output logic start,
  output logic stop
);

  logic c_scl;
  logic p_scl;
  logic p_sda;

  // Samples reset to the idle bus level so leaving reset never looks like
  // an edge on either line.
  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      c_scl <= LINE_IDLE;
      c_sda <= LINE_IDLE;
      p_scl <= LINE_IDLE;
      p_sda <= LINE_IDLE;
    end else begin
      p_scl <= c_scl;
      p_sda <= c_sda;
      c_scl <= scl;
      c_sda <= sda;
    end
  end

  // start/stop require scl high in both samples, so they can never
  // coincide with rise.
  assign rise  = !p_scl && c_scl;
  assign start = p_scl && c_scl && p_sda && !c_sda;
  assign stop  = p_scl && c_scl && !p_sda && c_sda;

endmodule

// File: rtl/sda_to_par.sv
// sda_to_par: serial-to-parallel receiver for the scl/sda link. Waits for a
// start, shifts DATA_W bits MSB-first on scl rises and presents the word as
// binary plus a registered one-hot decode. Stop, repeated start and aborted
// frames are recognised. DATA_W must be at least 2.
//   sclk       in  system clock
//   rst        in  asynchronous active-low reset
//   scl        in  link clock (sampled only)
//   sda        in  link data
//   data       out last complete word, held until the next complete frame
//   onehot     out registered decode of data (bit[data] set)
//   valid      out one-cycle pulse when data/onehot update
//   busy       out high while a frame is open
//   frame_err  out one-cycle pulse when a frame is aborted
module sda_to_par
  import sda_link_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                 sclk,
  input  logic                 rst,
  input  logic                 scl,
  input  logic                 sda,
  output logic [DATA_W-1:0]    data,
  output logic [2**DATA_W-1:0] onehot,
  output logic                 valid,
  output logic                 busy,
  output logic                 frame_err
);

  localparam int OH_W  = 2**DATA_W;
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  logic c_sda;
  logic rise;
  logic start;
  logic stop;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] word;

  sda_link_sampler u_sampler (
    .sclk  (sclk),
    .rst   (rst),
    .scl   (scl),
    .sda   (sda),
    .c_sda (c_sda),
    .rise  (rise),
    .start (start),
    .stop  (stop)
  );

  // Shift register contents after taking the current bit; the oldest bit
  // drops off the top.
  assign word = DATA_W'({sh, c_sda});

  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sh        <= '0;
      data      <= '0;
      onehot    <= '0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= BITS;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        BITS: begin
          if (start) begin
            // Restart the frame in place; busy stays high.
            frame_err <= 1'b1;
            cnt       <= '0;
          end else if (stop) begin
            frame_err <= 1'b1;
            state     <= IDLE;
            busy      <= 1'b0;
          end else if (rise) begin
            sh <= word;
            if (cnt == CNT_LAST) begin
              data   <= word;
              onehot <= OH_W'(1) << word;
              valid  <= 1'b1;
              state  <= STOP;
              cnt    <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (start) begin
            state <= BITS;
            cnt   <= '0;
          end else if (stop || (rise && c_sda)) begin
            // A rise with sda high covers a transmitter that parks sda
            // high instead of producing a stop edge.
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/sda_to_par.md
# sda_to_par

Serial-to-parallel receiver for the two-wire scl/sda link driven by the team's parallel-to-serial transmitter. It watches the link for a start condition, shifts in DATA_W data bits MSB-first on scl rising edges, and presents the word both as binary and as a registered one-hot decode. It also recognises stop, repeated start and malformed frames. It sits at the far end of the link, in the same sclk domain as the transmitter.

## Interface
- DATA_W, 4, data bits per frame; one-hot output width is 2**DATA_W.
- sclk  in  1  system clock; all state updates on posedge sclk.
- rst  in  1  reset, asynchronous, active-low.
- scl  in  1  link clock; sampled, never used as a clock.
- sda  in  1  link data; receive-only; an undriven (z) line reads as 1 via pull-up.
- data  out  DATA_W  last complete word; held until the next complete frame.
- onehot  out  2**DATA_W  registered decode of data, bit[data] = 1.
- valid  out  1  one-cycle pulse when data/onehot update.
- busy  out  1  high while a frame is open (state != IDLE).
- frame_err  out  1  one-cycle pulse when a frame is aborted.

## Operation
- Line sampler: each posedge registers scl and sda into c_scl/c_sda; the previous samples move to p_scl/p_sda. All four reset to 1 (idle bus).
- Event decode, combinational from the sample registers:
  - rise = !p_scl & c_scl
  - start = p_scl & c_scl & p_sda & !c_sda
  - stop = p_scl & c_scl & !p_sda & c_sda
  - rise is mutually exclusive with start and stop by construction.
- Bus requirement: scl high and low phases each last ≥ 2 sclk periods; sda changes ≥ 1 sclk away from scl edges. Slower links must meet this; faster links are out of spec.
- FSM states IDLE, BITS, STOP; bit counter cnt of $clog2(DATA_W) bits; shift register sh of DATA_W bits.
- IDLE:
  - start -> BITS, cnt = 0.
  - All other activity is ignored, including sda toggling while scl is low.
- BITS:
  - rise -> sh = {sh[DATA_W-2:0], c_sda} and cnt++.
  - On the rise with cnt == DATA_W-1 -> data = assembled word, onehot = 1 << word, valid = 1, go to STOP.
  - start -> frame_err = 1, cnt = 0, stay in BITS (restart the frame).
  - stop -> frame_err = 1, go to IDLE; data and onehot are unchanged.
- STOP:
  - stop -> IDLE.
  - start -> BITS, cnt = 0 (repeated start; no error).
  - rise with c_sda = 1 -> IDLE. This tolerates a transmitter that parks sda high without generating a stop edge.
  - rise with c_sda = 0 -> ignored.
- Arithmetic: cnt wraps only through the explicit reset to 0; onehot is the full 2**DATA_W-bit shift of the word.

## Timing
- Reset values: data = 0, onehot = 0, valid = 0, busy = 0, frame_err = 0, state = IDLE, sh = 0, cnt = 0, sample registers = 1.
- Latency: a line level present at posedge n is in c_* after n. Any resulting event acts at posedge n+1, so outputs change 2 sclk edges after the line change.
- The valid pulse lasts exactly 1 cycle. data and onehot change only on the valid cycle.
- busy rises on the cycle the start is acted on and falls on the cycle IDLE is entered.
- frame_err and valid never assert together.
- Reset mid-frame: all state returns to reset values immediately (asynchronous). A partial frame is discarded without frame_err; the next frame needs a fresh start.

## Structure
- Package sda_link_pkg contains:
  - the state enum (IDLE, BITS, STOP);
  - the DATA_W default;
  - the idle line level constant (1'b1).
  The transmitter shares this package.
- Sub-module sda_link_sampler: the sample registers plus the rise/start/stop decode. The receiver FSM, shift register and output registers live in sda_to_par.

## Test plan
- Start, bits 1,0,1,0, then stop -> data = 4'hA, onehot = 16'h0400, one valid pulse, busy high then low, frame_err = 0.
- Frame 4'h0, then repeated start, then 4'hF and stop -> two valid pulses, onehot 16'h0001 then 16'h8000, busy high throughout.
- Start, 2 bits, then stop -> single frame_err pulse, busy = 0, data and onehot keep their prior values (4'hA / 16'h0400 after the first test).
- Frame 4'h3 whose 5th scl rise has sda = 1 and no stop edge -> valid with data = 3 and onehot = 16'h0008, then IDLE and busy = 0.
- rst low during bit 3 -> all outputs 0 on the same cycle. After release, full frame 4'h5 -> data = 5, onehot = 16'h0020.
- sda toggled only while scl is low in IDLE, for 20 cycles -> busy, valid and frame_err all stay 0.
